// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues imem requests and feeds IF/ID with words, bubbles or holds.
// Zero-wait memory delivers one instruction per cycle; one fetched word is buffered across a hazard stall.
`timescale 1ns/1ps
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Jump,
    input  logic [31:0] Jump_Target,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic        Flush,
    output logic        ifId_Write
);

    typedef enum logic [1:0] {FETCH, HOLD, SQUASH} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] buffer, buffer_nxt;
    logic [31:0] sq_addr, sq_addr_nxt;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus;

    assign redirect = ~Stall & (Branch_Taken | Jump);
    assign target   = (Branch_Taken ? Branch_Target : Jump_Target) & ~32'd3;
    assign pc_plus  = pc + PC_INC;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            buffer  <= '0;
            sq_addr <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            buffer  <= buffer_nxt;
            sq_addr <= sq_addr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        buffer_nxt  = buffer;
        sq_addr_nxt = sq_addr;
        case (state)
            FETCH: begin
                if (redirect) begin
                    pc_nxt = target;
                    if (!imem_ready) begin
                        sq_addr_nxt = pc;
                        state_nxt   = SQUASH;
                    end
                end else if (imem_ready) begin
                    pc_nxt = pc_plus;
                    if (Stall) begin
                        buffer_nxt = imem_rdata;
                        state_nxt  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!Stall) begin
                    if (redirect) pc_nxt = target;
                    state_nxt = FETCH;
                end
            end
            SQUASH: begin
                // Keep retargeting until the stale word drains; the last target wins.
                if (redirect) pc_nxt = target;
                if (imem_ready) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = pc;
        Instruction = '0;
        PC          = RESET_PC;
        Flush       = 1'b0;
        ifId_Write  = 1'b1;
        if (reset) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (!Stall) begin
                        ifId_Write = 1'b0;
                        if (imem_ready && !redirect) begin
                            Instruction = imem_rdata;
                            PC          = pc_plus;
                        end else begin
                            Flush = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // pc already advanced past the buffered word, so it is that word's PC+4.
                    if (!Stall) begin
                        ifId_Write = 1'b0;
                        if (redirect) begin
                            Flush = 1'b1;
                        end else begin
                            Instruction = buffer;
                            PC          = pc;
                        end
                    end
                end
                SQUASH: begin
                    imem_req  = 1'b1;
                    imem_addr = sq_addr;
                    if (!Stall) begin
                        ifId_Write = 1'b0;
                        Flush      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, wait states, stall hold, redirects, wrap.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        Jump;
    logic [31:0] Jump_Target;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        Flush;
    logic        ifId_Write;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .Stall(Stall),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
        .Jump(Jump), .Jump_Target(Jump_Target),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .Instruction(Instruction), .PC(PC), .Flush(Flush), .ifId_Write(ifId_Write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) chk({tag, ".addr"}, imem_addr, addr);
    endtask

    task automatic chk_deliver(input string tag, input logic req, input logic [31:0] addr,
                               input logic [31:0] instr, input logic [31:0] pc4);
        chk_req(tag, req, addr);
        chk({tag, ".instr"}, Instruction, instr);
        chk({tag, ".pc"}, PC, pc4);
        chk({tag, ".flush"}, {31'd0, Flush}, 32'd0);
        chk({tag, ".wr"}, {31'd0, ifId_Write}, 32'd0);
    endtask

    task automatic chk_bubble(input string tag, input logic req, input logic [31:0] addr);
        chk_req(tag, req, addr);
        chk({tag, ".flush"}, {31'd0, Flush}, 32'd1);
        chk({tag, ".wr"}, {31'd0, ifId_Write}, 32'd0);
    endtask

    task automatic chk_hold(input string tag, input logic req, input logic [31:0] addr);
        chk_req(tag, req, addr);
        chk({tag, ".flush"}, {31'd0, Flush}, 32'd0);
        chk({tag, ".wr"}, {31'd0, ifId_Write}, 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0; Branch_Target = '0;
        Jump = 1'b0; Jump_Target = '0; imem_ready = 1'b1; imem_rdata = 32'h1111_0000;

        // Reset state
        #2;
        chk_hold("rst", 1'b0, 32'h0);
        chk("rst.instr", Instruction, 32'h0);
        chk("rst.pc", PC, 32'h0040_0000);
        tick();
        chk_hold("rst2", 1'b0, 32'h0);

        // Streaming with zero-wait memory
        reset = 1'b1; #1;
        chk_deliver("s0", 1'b1, 32'h0040_0000, 32'h1111_0000, 32'h0040_0004);
        tick(); imem_rdata = 32'h1111_0004; #1;
        chk_deliver("s1", 1'b1, 32'h0040_0004, 32'h1111_0004, 32'h0040_0008);
        tick(); imem_rdata = 32'h1111_0008; #1;
        chk_deliver("s2", 1'b1, 32'h0040_0008, 32'h1111_0008, 32'h0040_000C);

        // Two wait states per access
        tick(); imem_ready = 1'b0; #1;
        chk_bubble("w0", 1'b1, 32'h0040_000C);
        tick(); #1;
        chk_bubble("w1", 1'b1, 32'h0040_000C);
        tick(); imem_ready = 1'b1; imem_rdata = 32'h2222_000C; #1;
        chk_deliver("w2", 1'b1, 32'h0040_000C, 32'h2222_000C, 32'h0040_0010);

        // Stall without ready: IF/ID holds and pc does not move
        tick(); imem_ready = 1'b0; Stall = 1'b1; #1;
        chk_hold("sn", 1'b1, 32'h0040_0010);

        // Stall on a ready cycle -> HOLD; Jump while stalled is ignored
        tick(); imem_ready = 1'b1; imem_rdata = 32'hCAFE_0010; #1;
        chk_hold("st0", 1'b1, 32'h0040_0010);
        tick(); imem_rdata = 32'hBAD0_BAD0; #1;
        chk_hold("st1", 1'b0, 32'h0);
        tick(); Jump = 1'b1; Jump_Target = 32'h0050_0000; #1;
        chk_hold("st2", 1'b0, 32'h0);
        tick(); Jump = 1'b0; Stall = 1'b0; #1;
        chk_deliver("st3", 1'b0, 32'h0, 32'hCAFE_0010, 32'h0040_0014);
        tick(); imem_rdata = 32'h3333_0014; #1;
        chk_deliver("st4", 1'b1, 32'h0040_0014, 32'h3333_0014, 32'h0040_0018);

        // Branch while request waiting -> SQUASH; second redirect overrides target
        tick(); imem_ready = 1'b0; Branch_Taken = 1'b1; Branch_Target = 32'h0040_0103; #1;
        chk_bubble("sq0", 1'b1, 32'h0040_0018);
        tick(); Branch_Taken = 1'b0; #1;
        chk_bubble("sq1", 1'b1, 32'h0040_0018);
        tick(); Jump = 1'b1; Jump_Target = 32'h0040_0200; #1;
        chk_bubble("sq2", 1'b1, 32'h0040_0018);
        tick(); Jump = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_DEAD; #1;
        chk_bubble("sq3", 1'b1, 32'h0040_0018);
        tick(); imem_rdata = 32'h4444_0200; #1;
        chk_deliver("sq4", 1'b1, 32'h0040_0200, 32'h4444_0200, 32'h0040_0204);

        // Branch and Jump together on a ready cycle: branch wins, word dropped
        tick(); Branch_Taken = 1'b1; Branch_Target = 32'h0040_0302;
        Jump = 1'b1; Jump_Target = 32'h0040_0400; #1;
        chk_bubble("bj0", 1'b1, 32'h0040_0204);
        tick(); Branch_Taken = 1'b0; Jump = 1'b0; imem_rdata = 32'h5555_0300; #1;
        chk_deliver("bj1", 1'b1, 32'h0040_0300, 32'h5555_0300, 32'h0040_0304);

        // Jump in HOLD drops the buffered word
        tick(); Stall = 1'b1; imem_rdata = 32'h6666_0304; #1;
        chk_hold("hj0", 1'b1, 32'h0040_0304);
        tick(); Stall = 1'b0; Jump = 1'b1; Jump_Target = 32'h0040_0500; #1;
        chk_bubble("hj1", 1'b0, 32'h0);
        chk("hj1.instr_not_buf", {31'd0, Instruction === 32'h6666_0304}, 32'd0);
        tick(); Jump = 1'b0; imem_rdata = 32'h7777_0500; #1;
        chk_deliver("hj2", 1'b1, 32'h0040_0500, 32'h7777_0500, 32'h0040_0504);

        // PC wrap at the top of the address space
        tick(); Jump = 1'b1; Jump_Target = 32'hFFFF_FFFF; #1;
        chk_bubble("wr0", 1'b1, 32'h0040_0504);
        tick(); Jump = 1'b0; imem_rdata = 32'h8888_FFFC; #1;
        chk_deliver("wr1", 1'b1, 32'hFFFF_FFFC, 32'h8888_FFFC, 32'h0000_0000);
        tick(); imem_rdata = 32'h8888_0000; #1;
        chk_deliver("wr2", 1'b1, 32'h0000_0000, 32'h8888_0000, 32'h0000_0004);

        // Reset asserted during SQUASH
        tick(); imem_ready = 1'b0; Jump = 1'b1; Jump_Target = 32'h0040_0600; #1;
        chk_bubble("rs0", 1'b1, 32'h0000_0004);
        tick(); Jump = 1'b0; #1;
        chk_bubble("rs1", 1'b1, 32'h0000_0004);
        reset = 1'b0; #1;
        chk_hold("rs2", 1'b0, 32'h0);
        chk("rs2.pc", PC, 32'h0040_0000);
        tick(); reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h9999_0000; #1;
        chk_deliver("rs3", 1'b1, 32'h0040_0000, 32'h9999_0000, 32'h0040_0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
